// File: rtl/bsk_mgr_cut_wr_dispatch_if.sv
// Command, load-stream and cut-RAM write-port bundle of the bsk_manager cut write dispatcher.
interface bsk_mgr_cut_wr_dispatch_if #(
  parameter int BSK_CUT_NB = 8,
  parameter int DATA_W     = 64,
  parameter int CUT_DEPTH  = 256,
  parameter int SLOT_NB    = 4
);
  localparam int ADD_W  = $clog2(SLOT_NB * CUT_DEPTH);
  localparam int SLOT_W = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1;

  logic [SLOT_W-1:0]     cmd_slot;
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [DATA_W-1:0]     in_data;
  logic                  in_vld;
  logic                  in_rdy;
  logic [BSK_CUT_NB-1:0] wr_en;
  logic [ADD_W-1:0]      wr_add;
  logic [DATA_W-1:0]     wr_data;
  logic                  busy;
  logic                  done;
  logic [SLOT_W-1:0]     done_slot;

  modport slave (
    input  cmd_slot, cmd_vld, in_data, in_vld,
    output cmd_rdy, in_rdy, wr_en, wr_add, wr_data, busy, done, done_slot
  );

  modport master (
    output cmd_slot, cmd_vld, in_data, in_vld,
    input  cmd_rdy, in_rdy, wr_en, wr_add, wr_data, busy, done, done_slot
  );
endinterface

// File: rtl/bsk_mgr_cut_wr_dispatch.sv
// Write-side feeder of the bsk_manager cut RAMs: loads one BSK slot by spreading the
// incoming word stream round-robin over the cuts through registered write ports.
module bsk_mgr_cut_wr_dispatch #(
  parameter int BSK_CUT_NB = 8,
  parameter int DATA_W     = 64,
  parameter int CUT_DEPTH  = 256,
  parameter int SLOT_NB    = 4
) (
  input  logic                      clk,
  input  logic                      s_rst,
  bsk_mgr_cut_wr_dispatch_if.slave  io
);
  localparam int ADD_W  = $clog2(SLOT_NB * CUT_DEPTH);
  localparam int SLOT_W = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1;
  localparam int CUT_W  = (BSK_CUT_NB > 1) ? $clog2(BSK_CUT_NB) : 1;
  localparam int ROW_W  = $clog2(CUT_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CUT_W-1:0]      cut_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic [SLOT_W-1:0]     cur_slot;
  logic [BSK_CUT_NB-1:0] wr_en_q;
  logic [ADD_W-1:0]      wr_add_q;
  logic [DATA_W-1:0]     wr_data_q;

  logic cmd_acc;
  logic word_acc;
  logic cut_wrap;
  logic last_word;

  assign cmd_acc   = (state == ST_IDLE) && io.cmd_vld;
  assign word_acc  = (state == ST_LOAD) && io.in_vld;
  assign cut_wrap  = (cut_cnt == CUT_W'(BSK_CUT_NB - 1));
  assign last_word = cut_wrap && (row_cnt == ROW_W'(CUT_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (s_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    io.cmd_rdy = 1'b0;
    io.in_rdy  = 1'b0;
    io.busy    = 1'b0;
    io.done    = 1'b0;
    case (state)
      ST_IDLE: begin
        io.cmd_rdy = 1'b1;
        if (io.cmd_vld) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        io.in_rdy = 1'b1;
        io.busy   = 1'b1;
        if (io.in_vld && last_word) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        io.busy   = 1'b1;
        io.done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write port is registered, so the last word's write lands in the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      cut_cnt   <= '0;
      row_cnt   <= '0;
      cur_slot  <= '0;
      wr_en_q   <= '0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= '0;
      if (cmd_acc) begin
        cur_slot <= io.cmd_slot;
        cut_cnt  <= '0;
        row_cnt  <= '0;
      end
      if (word_acc) begin
        wr_en_q   <= BSK_CUT_NB'(1) << cut_cnt;
        wr_add_q  <= ADD_W'({cur_slot, row_cnt});
        wr_data_q <= io.in_data;
        if (cut_wrap) begin
          cut_cnt <= '0;
          row_cnt <= row_cnt + ROW_W'(1);
        end else begin
          cut_cnt <= cut_cnt + CUT_W'(1);
        end
      end
    end
  end

  assign io.wr_en     = wr_en_q;
  assign io.wr_add    = wr_add_q;
  assign io.wr_data   = wr_data_q;
  assign io.done_slot = cur_slot;
endmodule

// File: tb/tb_bsk_mgr_cut_wr_dispatch.sv
// Randomized bench for bsk_mgr_cut_wr_dispatch against a word-index reference model.
module tb_bsk_mgr_cut_wr_dispatch;
  localparam int NB    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 256;
  localparam int SLOTS = 4;
  localparam int AW    = 10;
  localparam int SW    = 2;
  localparam int WORDS = NB * DEPTH;

  logic clk = 1'b0;
  logic s_rst;
  always #5 clk = ~clk;

  bsk_mgr_cut_wr_dispatch_if #(
    .BSK_CUT_NB(NB), .DATA_W(DW), .CUT_DEPTH(DEPTH), .SLOT_NB(SLOTS)
  ) bus ();

  bsk_mgr_cut_wr_dispatch #(
    .BSK_CUT_NB(NB), .DATA_W(DW), .CUT_DEPTH(DEPTH), .SLOT_NB(SLOTS)
  ) dut (
    .clk   (clk),
    .s_rst (s_rst),
    .io    (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: a load is a count of accepted words; word k maps to
  // cut k%NB at address slot*DEPTH + k/NB.
  bit            m_loading;
  bit            m_done;
  int            m_cnt;
  int            m_slot;
  logic [NB-1:0] m_wen;
  logic [AW-1:0] m_add;
  logic [DW-1:0] m_data;
  int            dut_ndone;
  int            hits [NB][SLOTS*DEPTH];
  bit            hit_on;

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick(input bit rst, input bit cv, input int cs, input bit iv,
                      input logic [DW-1:0] d);
    bit was_done;
    s_rst        = rst;
    bus.cmd_vld  = cv;
    bus.cmd_slot = SW'(cs);
    bus.in_vld   = iv;
    bus.in_data  = d;
    @(posedge clk);
    if (rst) begin
      m_loading = 1'b0;
      m_done    = 1'b0;
      m_cnt     = 0;
      m_slot    = 0;
      m_wen     = '0;
      m_add     = '0;
      m_data    = '0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      m_wen    = '0;
      if (was_done) begin
        // single completion cycle: nothing accepted
      end else if (m_loading) begin
        if (iv) begin
          m_wen  = NB'(1) << (m_cnt % NB);
          m_add  = AW'(m_slot * DEPTH + m_cnt / NB);
          m_data = d;
          m_cnt++;
          if (m_cnt == WORDS) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end
      end else if (cv) begin
        m_loading = 1'b1;
        m_slot    = cs;
        m_cnt     = 0;
      end
    end
    @(negedge clk);
    check("wr_en",   bus.wr_en,   m_wen);
    check("wr_add",  bus.wr_add,  m_add);
    check("wr_data", bus.wr_data, m_data);
    check("done",    bus.done,    m_done);
    check("busy",    bus.busy,    m_loading || m_done);
    check("cmd_rdy", bus.cmd_rdy, !m_loading && !m_done);
    check("in_rdy",  bus.in_rdy,  m_loading);
    if (m_done) check("done_slot", bus.done_slot, m_slot);
    if (bus.done === 1'b1) dut_ndone++;
    if (hit_on)
      for (int b = 0; b < NB; b++)
        if (bus.wr_en[b] === 1'b1) hits[b][bus.wr_add]++;
  endtask

  task automatic clear_hits();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < SLOTS * DEPTH; a++) hits[b][a] = 0;
  endtask

  task automatic region_stats(input int slot, output int ok, output int tot);
    ok  = 0;
    tot = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < SLOTS * DEPTH; a++) begin
        tot += hits[b][a];
        if (a / DEPTH == slot && hits[b][a] == 1) ok++;
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0;
    int ok;
    int tot;
    s_rst        = 1'b1;
    bus.cmd_vld  = 1'b0;
    bus.cmd_slot = '0;
    bus.in_vld   = 1'b0;
    bus.in_data  = '0;
    m_loading = 0; m_done = 0; m_cnt = 0; m_slot = 0;
    m_wen = '0; m_add = '0; m_data = '0; dut_ndone = 0; hit_on = 0;
    @(negedge clk);

    // Reset held 3 cycles
    repeat (3) tick(1, 0, 0, 0, '0);
    check("rst_cmd_rdy", bus.cmd_rdy, 1);
    check("rst_in_rdy",  bus.in_rdy,  0);
    check("rst_wr_en",   bus.wr_en,   0);
    check("rst_busy",    bus.busy,    0);

    // Words offered while idle are ignored
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 1, rnd64());
      check("idle_in_rdy", bus.in_rdy, 0);
      check("idle_wr_en",  bus.wr_en,  0);
    end

    // Full back-to-back load of slot 2, data = index
    tick(0, 1, 2, 0, '0);
    for (int k = 0; k < WORDS; k++) begin
      tick(0, 0, 0, 1, DW'(k));
      if (k == 9) begin
        check("t2_w9_en",  bus.wr_en,  8'h02);
        check("t2_w9_add", bus.wr_add, 513);
      end
      if (k == WORDS - 1) begin
        check("t2_last_en",   bus.wr_en,     8'h80);
        check("t2_last_add",  bus.wr_add,    767);
        check("t2_last_data", bus.wr_data,   2047);
        check("t2_done",      bus.done,      1);
        check("t2_done_slot", bus.done_slot, 2);
      end
    end
    tick(0, 0, 0, 0, '0);
    check("t2_done_pulse", bus.done, 0);

    // Slot 0 with ~30% input gaps
    clear_hits();
    hit_on = 1;
    nd0 = dut_ndone;
    tick(0, 1, 0, 0, '0);
    for (int c = 0; c < 8000 && dut_ndone == nd0; c++)
      tick(0, 0, 0, $urandom_range(99) >= 30, rnd64());
    tick(0, 0, 0, 0, '0);
    hit_on = 0;
    region_stats(0, ok, tot);
    check("t3_cells", ok, WORDS);
    check("t3_total", tot, WORDS);
    check("t3_ndone", dut_ndone - nd0, 1);

    // Slot 3 load with a slot-1 command held pending throughout
    clear_hits();
    hit_on = 1;
    nd0 = dut_ndone;
    tick(0, 1, 3, 0, '0);
    for (int c = 0; c < 8000 && dut_ndone == nd0; c++)
      tick(0, 1, 1, $urandom_range(99) >= 30, rnd64());
    hit_on = 0;
    region_stats(3, ok, tot);
    check("t4_cells", ok, WORDS);
    check("t4_total", tot, WORDS);
    check("t4_ndone", dut_ndone - nd0, 1);
    tick(0, 1, 1, 0, '0);
    check("t4_after_done_cmd_rdy", bus.cmd_rdy, 1);
    tick(0, 1, 1, 0, '0);
    check("t4_accept_busy",    bus.busy,    1);
    check("t4_accept_cmd_rdy", bus.cmd_rdy, 0);

    // Slot-1 load aborted by reset after 1000 words
    nd0 = dut_ndone;
    for (int c = 0; c < 4000 && m_cnt < 1000; c++)
      tick(0, 0, 0, $urandom_range(99) >= 30, rnd64());
    check("t5_words", m_cnt, 1000);
    tick(1, 0, 0, 0, '0);
    check("t5_rst_done",    bus.done,    0);
    check("t5_rst_busy",    bus.busy,    0);
    check("t5_rst_cmd_rdy", bus.cmd_rdy, 1);
    check("t5_ndone",       dut_ndone - nd0, 0);
    tick(0, 1, 3, 0, '0);
    tick(0, 0, 0, 1, rnd64());
    check("t5_first_en",  bus.wr_en,  8'h01);
    check("t5_first_add", bus.wr_add, 768);
    for (int c = 0; c < 4000 && dut_ndone == nd0; c++)
      tick(0, 0, 0, 1, rnd64());
    check("t5_ndone_end", dut_ndone - nd0, 1);
    tick(0, 0, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
